bcd_operand_entry: RTL and testbench

Keypad front end for the BCD adder datapath. Synchronizes and edge-detects push-button presses, lets the user enter one BCD digit for operand A, one for operand B, and a carry-in. It then presents the pair with a valid/ready handshake to the downstream BCD add stage and its display latch. Sits directly between the `pb` pins and the adder inputs.

---
 rtl/bcd_operand_entry.sv | 210 +++++++++++++++++++++
 tb/tb_bcd_operand_entry.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: keypad front end for the BCD adder.
// Raw push-buttons are synchronized and edge-detected. The user then enters a
// BCD digit for operand A, a BCD digit for operand B, and a carry-in. The
// committed pair is offered downstream with a valid/ready handshake.
// Optional feature macro: BCD_ENTRY_DEBOUNCE_EN adds a per-key debounce
// filter of DEBOUNCE_CYCLES stable samples ahead of the edge detector.
module bcd_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic [9:0] digit_key,
  input  logic       enter_key,
  input  logic       clear_key,
  input  logic       cin_key,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       cin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] phase,
  output logic       multi_err
);

  // Key vector layout: digits in [9:0], then enter, cin, clear.
  localparam int NKEYS     = 13;
  localparam int KEY_ENTER = 10;
  localparam int KEY_CIN   = 11;
  localparam int KEY_CLEAR = 12;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_PRESENT = 2'b10
  } state_t;

  logic [NKEYS-1:0] w_raw;
  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;
  logic [NKEYS-1:0] w_level;
  logic [NKEYS-1:0] r_prev;
  logic [NKEYS-1:0] w_press;

  logic [9:0]       w_digits;
  logic             w_any_digit;
  logic             w_multi;
  logic [3:0]       w_digit_val;

  state_t           r_state;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic             r_cin;
  logic             r_a_set;
  logic             r_b_set;
  logic             r_out_valid;
  logic             r_multi_err;

  assign w_raw = {clear_key, cin_key, enter_key, digit_key};

  // Two-flop synchronizer on every raw key.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BCD_ENTRY_DEBOUNCE_EN
  // The accepted level flips once the synchronized key has disagreed with it
  // on DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts it.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] r_level;
  logic [7:0]       r_cnt [NKEYS];

  // Per-key debounce counters and accepted levels.
  // NOTE: the counter array is reset along with everything else because it is
  // control state; a power-up count would otherwise accept a phantom press.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
      for (int i = 0; i < NKEYS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_level = r_level;
`else
  // Without the filter the parameter has no effect; keep it referenced.
  logic w_unused_debounce;
  assign w_unused_debounce = (DEBOUNCE_CYCLES > 0);
  assign w_level = r_sync2;
`endif

  // Previous accepted level, for rising-edge detection.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) r_prev <= '0;
    else        r_prev <= w_level;
  end

  assign w_press     = w_level & ~r_prev;
  assign w_digits    = w_press[9:0];
  assign w_any_digit = |w_digits;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi     = |(w_digits & (w_digits - 10'd1));

  // Encode the pressed digit; only meaningful when exactly one digit is set,
  // so the result is always in 0..9.
  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_digit_val = '0;
    for (int i = 0; i < 10; i++) begin
      if (w_digits[i]) w_digit_val = 4'(i);
    end
  end

  // Entry FSM with registered operands, handshake and error pulse.
  // Priority per cycle: clear > enter > digit > cin. An enter press that is
  // not allowed to advance the state is ignored and lets lower keys through.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ENTER_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_cin       <= 1'b0;
      r_a_set     <= 1'b0;
      r_b_set     <= 1'b0;
      r_out_valid <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_multi_err <= w_multi;
      if (w_press[KEY_CLEAR]) begin
        r_state     <= ST_ENTER_A;
        r_op_a      <= '0;
        r_op_b      <= '0;
        r_cin       <= 1'b0;
        r_a_set     <= 1'b0;
        r_b_set     <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_ENTER_A: begin
            if (w_press[KEY_ENTER] && r_a_set) begin
              r_state <= ST_ENTER_B;
            end else if (w_any_digit) begin
              if (!w_multi) begin
                r_op_a  <= w_digit_val;
                r_a_set <= 1'b1;
              end
            end else if (w_press[KEY_CIN]) begin
              r_cin <= ~r_cin;
            end
          end
          ST_ENTER_B: begin
            if (w_press[KEY_ENTER] && r_b_set) begin
              r_state     <= ST_PRESENT;
              r_out_valid <= 1'b1;
            end else if (w_any_digit) begin
              if (!w_multi) begin
                r_op_b  <= w_digit_val;
                r_b_set <= 1'b1;
              end
            end else if (w_press[KEY_CIN]) begin
              r_cin <= ~r_cin;
            end
          end
          ST_PRESENT: begin
            if (r_out_valid && out_ready) begin
              r_state     <= ST_ENTER_A;
              r_op_a      <= '0;
              r_op_b      <= '0;
              r_cin       <= 1'b0;
              r_a_set     <= 1'b0;
              r_b_set     <= 1'b0;
              r_out_valid <= 1'b0;
            end
          end
          default: begin
            r_state     <= ST_ENTER_A;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign cin       = r_cin;
  assign out_valid = r_out_valid;
  assign phase     = r_state;
  assign multi_err = r_multi_err;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Testbench for bcd_operand_entry: directed scenarios with fixed expectations
// plus randomized key traffic compared cycle by cycle against a reference
// model built from key-press history (default build only).
module tb_bcd_operand_entry;

  localparam int DEB = 4;
`ifdef BCD_ENTRY_DEBOUNCE_EN
  localparam int HOLD = DEB + 1;
`else
  localparam int HOLD = 1;
`endif
  localparam int IDLE = HOLD + 5;

  localparam logic [12:0] K_ENTER = 13'h0400;
  localparam logic [12:0] K_CIN   = 13'h0800;
  localparam logic [12:0] K_CLEAR = 13'h1000;

  logic        clk;
  logic        rst_n;
  logic [12:0] r_raw;
  logic        r_ready;
  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic        cin;
  logic        out_valid;
  logic [1:0]  phase;
  logic        multi_err;

  int n_vec;
  int n_err;

  // Observation counters for windowed checks.
  int s_valid_low;
  int s_mpulse;
  int s_ctrans;
  logic s_last_cin;

  // Reference model: raw-key history and architectural state.
  logic [12:0] m_h0, m_h1, m_h2, m_h3;
  int          m_phase;
  int          m_a, m_b;
  bit          m_cin, m_a_set, m_b_set, m_multi;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .hz100     (clk),
    .reset     (rst_n),
    .digit_key (r_raw[9:0]),
    .enter_key (r_raw[10]),
    .clear_key (r_raw[12]),
    .cin_key   (r_raw[11]),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (r_ready),
    .phase     (phase),
    .multi_err (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h0 = '0; m_h1 = '0; m_h2 = '0; m_h3 = '0;
    m_phase = 0; m_a = 0; m_b = 0;
    m_cin = 0; m_a_set = 0; m_b_set = 0; m_multi = 0;
  endtask

  task automatic model_clear();
    m_phase = 0; m_a = 0; m_b = 0;
    m_cin = 0; m_a_set = 0; m_b_set = 0;
  endtask

  // One rising edge of the model: a key sampled at edge n-2 that was low at
  // edge n-3 is a press acted on at edge n.
  task automatic model_edge();
    logic [12:0] pr;
    int nd;
    int val;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = m_h0; m_h0 = r_raw;
    pr = m_h2 & ~m_h3;
    nd = $countones(pr[9:0]);
    val = 0;
    for (int i = 0; i < 10; i++) if (pr[i]) val = i;
    m_multi = (nd >= 2);
    if (pr[12]) begin
      model_clear();
    end else if (m_phase == 2) begin
      if (r_ready) model_clear();
    end else if (pr[10] && (m_phase == 0 ? m_a_set : m_b_set)) begin
      m_phase = m_phase + 1;
    end else if (nd == 1) begin
      if (m_phase == 0) begin m_a = val; m_a_set = 1; end
      else              begin m_b = val; m_b_set = 1; end
    end else if (nd == 0 && pr[11]) begin
      m_cin = !m_cin;
    end
  endtask

  // Advance one clock: inputs are already applied; outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
`ifndef BCD_ENTRY_DEBOUNCE_EN
    check("m_op_a",  32'(op_a),      m_a);
    check("m_op_b",  32'(op_b),      m_b);
    check("m_cin",   32'(cin),       32'(m_cin));
    check("m_valid", 32'(out_valid), (m_phase == 2) ? 1 : 0);
    check("m_phase", 32'(phase),     m_phase);
    check("m_multi", 32'(multi_err), 32'(m_multi));
`endif
    if (!out_valid) s_valid_low++;
    if (multi_err) s_mpulse++;
    if (cin !== s_last_cin) s_ctrans++;
    s_last_cin = cin;
  endtask

  task automatic press(input logic [12:0] keys, input int hold);
    r_raw = keys;
    repeat (hold) step();
    r_raw = '0;
    repeat (IDLE) step();
  endtask

  task automatic dig(input int d);
    press(13'(1) << d, HOLD);
  endtask

  task automatic clear_all();
    press(K_CLEAR, HOLD);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    s_valid_low = 0; s_mpulse = 0; s_ctrans = 0; s_last_cin = 1'b0;
    r_raw = '0; r_ready = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_op_a",  32'(op_a), 0);
    check("rst_op_b",  32'(op_b), 0);
    check("rst_cin",   32'(cin), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_multi", 32'(multi_err), 0);
    rst_n = 1'b1;
    step();

    // Enter without a digit is ignored.
    press(K_ENTER, HOLD);
    check("guard_phase", 32'(phase), 0);

    // Basic entry.
    dig(7); press(K_ENTER, HOLD); dig(5); press(K_ENTER, HOLD);
    check("basic_phase", 32'(phase), 2);
    check("basic_op_a",  32'(op_a), 7);
    check("basic_op_b",  32'(op_b), 5);
    check("basic_cin",   32'(cin), 0);
    check("basic_valid", 32'(out_valid), 1);
    r_ready = 1'b1; step(); r_ready = 1'b0;
    check("accept_valid", 32'(out_valid), 0);
    check("accept_phase", 32'(phase), 0);
    check("accept_op_a",  32'(op_a), 0);
    check("accept_op_b",  32'(op_b), 0);

    // Overwrite and carry.
    dig(3); dig(9); press(K_CIN, HOLD); press(K_ENTER, HOLD);
    dig(9); press(K_ENTER, HOLD);
    check("ovr_op_a",  32'(op_a), 9);
    check("ovr_op_b",  32'(op_b), 9);
    check("ovr_cin",   32'(cin), 1);
    check("ovr_phase", 32'(phase), 2);

    // Backpressure: presses ignored, valid held while ready stays low.
    s_valid_low = 0;
    dig(2); press(K_ENTER, HOLD);
    repeat (20) step();
    check("bp_valid_low", s_valid_low, 0);
    check("bp_op_a", 32'(op_a), 9);
    check("bp_op_b", 32'(op_b), 9);
    check("bp_cin",  32'(cin), 1);
    r_ready = 1'b1; step(); r_ready = 1'b0;
    check("bp_accept", 32'(out_valid), 0);

    // Collisions.
    dig(4);
    s_mpulse = 0;
    press((13'(1) << 4) | (13'(1) << 6), HOLD);
    check("col_mpulse", s_mpulse, 1);
    check("col_op_a", 32'(op_a), 4);
    press(K_ENTER, HOLD); dig(1);
    check("col_op_b", 32'(op_b), 1);
    press(K_ENTER | K_CLEAR, HOLD);
    check("clr_phase", 32'(phase), 0);
    check("clr_op_a",  32'(op_a), 0);
    check("clr_op_b",  32'(op_b), 0);
    check("clr_cin",   32'(cin), 0);

    // Held keys give exactly one press.
    press(13'(1) << 8, 50);
    check("hold_op_a", 32'(op_a), 8);
    s_ctrans = 0;
    press(K_CIN, 50);
    check("hold_cin_trans", s_ctrans, 1);
    check("hold_cin", 32'(cin), 1);
    clear_all();

`ifdef BCD_ENTRY_DEBOUNCE_EN
    // A glitch shorter than the filter is rejected, a full-length press taken.
    press(13'(1) << 1, DEB - 1);
    check("deb_glitch", 32'(op_a), 0);
    press(13'(1) << 1, DEB);
    check("deb_press", 32'(op_a), 1);
    clear_all();
`endif

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        int sel;
        sel = int'($urandom_range(0, 11));
        if (sel <= 4)       r_raw = 13'(1) << $urandom_range(0, 9);
        else if (sel == 5)  r_raw = (13'(1) << $urandom_range(0, 9)) | (13'(1) << $urandom_range(0, 9));
        else if (sel <= 7)  r_raw = K_ENTER;
        else if (sel == 8)  r_raw = K_CIN;
        else if (sel == 9)  r_raw = ($urandom_range(0, 3) == 0) ? K_CLEAR : 13'h0;
        else if (sel == 10) r_raw = K_ENTER | (13'(1) << $urandom_range(0, 9));
        else                r_raw = '0;
      end
      r_ready = 1'($urandom_range(0, 1));
      step();
    end
    r_raw = '0; r_ready = 1'b0;
    repeat (IDLE) step();
    clear_all();

    // Asynchronous reset in the middle of PRESENT.
    dig(2); press(K_ENTER, HOLD); dig(3); press(K_ENTER, HOLD);
    check("pre_rst_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_phase", 32'(phase), 0);
    check("arst_op_a",  32'(op_a), 0);
    check("arst_op_b",  32'(op_b), 0);
    check("arst_cin",   32'(cin), 0);
    check("arst_multi", 32'(multi_err), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s_last_cin = cin;
    press(K_ENTER, HOLD);
    check("arst_aset", 32'(phase), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
